// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder.
// Contents:
//   - MMIO_BASE_HI_DEF : default addr[31:16] value that selects the MMIO window
//   - *_OFS            : MMIO register word offsets (addr[15:2])
//   - region_e         : address decode result
//   - rd_src_e         : which registered source feeds data_sram_rdata
//   - lane_merge()     : byte-lane merge of a store into an existing word
package data_sram_responder_pkg;

    localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hbfaf;

    localparam logic [13:0] LED_OFS       = 14'h000;
    localparam logic [13:0] TIMER_OFS     = 14'h001;
    localparam logic [13:0] SCRATCH_OFS   = 14'h002;
    localparam logic [13:0] STORE_CNT_OFS = 14'h003;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    typedef enum logic {
        SRC_REG,
        SRC_RAM
    } rd_src_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  we);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_bank.sv
// dsram_bank: DEPTH x 32 single-port RAM with byte write enables and a
// synchronous read-first port. No reset, so a vendor block RAM can replace it.
// Ports:
//   clk   : clock
//   en    : access enable; rdata only updates when en=1
//   we    : byte-lane write enables (lane i = wdata[8i+7:8i])
//   addr  : word index
//   wdata : store data
//   rdata : word at addr before this cycle's write, valid the next cycle
module dsram_bank #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int unsigned i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the core data SRAM interface: word RAM with byte-lane
// writes, a small MMIO register window (LED, TIMER, SCRATCH, STORE_CNT) and
// one-cycle registered, read-first read data. Accesses hitting neither region
// return 0 and set a sticky error flag.
// Ports:
//   clk             : core clock
//   resetn          : asynchronous active-low reset
//   data_sram_en    : request valid this cycle
//   data_sram_we    : byte-lane write enables, 4'b0000 = read
//   data_sram_addr  : byte address, bits [1:0] ignored
//   data_sram_wdata : store data
//   data_sram_rdata : read data, valid the cycle after the request, held when idle
//   led_o           : LED register low half
//   err_o           : sticky unmapped-access flag
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led_o,
    output logic        err_o
);

    region_e     region;
    logic [13:0] mmio_ofs;
    logic [31:0] mmio_rval;
    logic        ram_en;
    logic        mmio_wr;
    logic        ram_store;
    logic [1:0]  unused_addr_lsb;

    logic [31:0] led_q;
    logic [31:0] timer_q;
    logic [31:0] scratch_q;
    logic [31:0] store_cnt_q;
    logic        err_q;

    rd_src_e     rd_src_q;
    logic [31:0] reg_rdata_q;
    logic [31:0] bank_rdata;

    assign unused_addr_lsb = data_sram_addr[1:0];

    always_comb begin
        region = REG_NONE;
        if (data_sram_addr[31:ADDR_W+2] == '0) begin
            region = REG_RAM;
        end else if (data_sram_addr[31:16] == MMIO_BASE_HI) begin
            region = REG_MMIO;
        end
    end

    assign mmio_ofs  = data_sram_addr[15:2];
    assign ram_en    = data_sram_en && (region == REG_RAM);
    assign mmio_wr   = data_sram_en && (region == REG_MMIO) && (data_sram_we != '0);
    assign ram_store = ram_en && (data_sram_we != '0);

    always_comb begin
        mmio_rval = '0;
        case (mmio_ofs)
            LED_OFS:       mmio_rval = led_q;
            TIMER_OFS:     mmio_rval = timer_q;
            SCRATCH_OFS:   mmio_rval = scratch_q;
            STORE_CNT_OFS: mmio_rval = store_cnt_q;
            default:       mmio_rval = '0;
        endcase
    end

    dsram_bank #(
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk  (clk),
        .en   (ram_en),
        .we   (data_sram_we),
        .addr (data_sram_addr[ADDR_W+1:2]),
        .wdata(data_sram_wdata),
        .rdata(bank_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q       <= '0;
            timer_q     <= '0;
            scratch_q   <= '0;
            store_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (mmio_wr && (mmio_ofs == LED_OFS)) begin
                led_q <= lane_merge(led_q, data_sram_wdata, data_sram_we);
            end
            if (mmio_wr && (mmio_ofs == SCRATCH_OFS)) begin
                scratch_q <= lane_merge(scratch_q, data_sram_wdata, data_sram_we);
            end
            // A write replaces the increment and merges against the pre-increment value.
            if (mmio_wr && (mmio_ofs == TIMER_OFS)) begin
                timer_q <= lane_merge(timer_q, data_sram_wdata, data_sram_we);
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            if (ram_store && (store_cnt_q != '1)) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
            if (data_sram_en && (region == REG_NONE)) begin
                err_q <= 1'b1;
            end
        end
    end

    // The RAM keeps its own read register; only the source select and the
    // register-side value are reset, which forces the visible output to 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_src_q    <= SRC_REG;
            reg_rdata_q <= '0;
        end else if (data_sram_en) begin
            rd_src_q    <= (region == REG_RAM) ? SRC_RAM : SRC_REG;
            reg_rdata_q <= (region == REG_MMIO) ? mmio_rval : '0;
        end
    end

    assign data_sram_rdata = (rd_src_q == SRC_RAM) ? bank_rdata : reg_rdata_q;
    assign led_o           = led_q[15:0];
    assign err_o           = err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led_o;
    logic        err_o;

    int passed;
    int total;

    data_sram_responder #(
        .ADDR_W      (14),
        .MMIO_BASE_HI(16'hbfaf)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .data_sram_en   (data_sram_en),
        .data_sram_we   (data_sram_we),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .led_o          (led_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle; returns 1 time unit after the capturing edge.
    task automatic bus(input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        data_sram_en = 1'b0;
        data_sram_we = 4'b0000;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        data_sram_en = 1'b0;
        data_sram_we = 4'b0000;
        data_sram_addr = '0;
        data_sram_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (data_sram_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
        total++;
        if (led_o !== 16'h0) $display("FAIL reset_led got=%h exp=%h", led_o, 16'h0);
        else passed++;
        total++;
        if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=%b", err_o, 1'b0);
        else passed++;
        resetn = 1'b1;
        bus(1'b1, 4'b0000, 32'hbfaf000c, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h0) $display("FAIL reset_store_cnt got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
    endtask

    task automatic test_store_load();
        bus(1'b1, 4'b1111, 32'h00000010, 32'h11223344);
        bus(1'b1, 4'b0000, 32'h00000010, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h11223344) $display("FAIL store_load got=%h exp=%h", data_sram_rdata, 32'h11223344);
        else passed++;
        bus(1'b1, 4'b0000, 32'hbfaf000c, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h1) $display("FAIL store_cnt_1 got=%h exp=%h", data_sram_rdata, 32'h1);
        else passed++;
    endtask

    task automatic test_partial();
        bus(1'b1, 4'b0101, 32'h00000010, 32'hAABBCCDD);
        bus(1'b1, 4'b0000, 32'h00000010, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h11BB33DD) $display("FAIL partial_lanes got=%h exp=%h", data_sram_rdata, 32'h11BB33DD);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bus(1'b1, 4'b1111, 32'h00000020, 32'hDEADBEEF);
        bus(1'b1, 4'b1111, 32'h00000020, 32'h00000055);
        total++;
        if (data_sram_rdata !== 32'hDEADBEEF) $display("FAIL store_read_first got=%h exp=%h", data_sram_rdata, 32'hDEADBEEF);
        else passed++;
        bus(1'b1, 4'b0000, 32'h00000020, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h00000055) $display("FAIL load_after_store got=%h exp=%h", data_sram_rdata, 32'h00000055);
        else passed++;
        bus(1'b0, 4'b0000, 32'h00000010, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h00000055) $display("FAIL idle_hold got=%h exp=%h", data_sram_rdata, 32'h00000055);
        else passed++;
    endtask

    task automatic test_timer();
        bus(1'b1, 4'b1111, 32'hbfaf0004, 32'hFFFFFFFE);
        bus(1'b0, 4'b0000, 32'h0, 32'h0);
        bus(1'b1, 4'b0000, 32'hbfaf0004, 32'h0);
        total++;
        if (data_sram_rdata !== 32'hFFFFFFFF) $display("FAIL timer_inc got=%h exp=%h", data_sram_rdata, 32'hFFFFFFFF);
        else passed++;
        bus(1'b1, 4'b0000, 32'hbfaf0004, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h00000000) $display("FAIL timer_wrap got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
    endtask

    task automatic test_mmio();
        bus(1'b1, 4'b1111, 32'hbfaf0000, 32'h0000ABCD);
        total++;
        if (led_o !== 16'hABCD) $display("FAIL led_out got=%h exp=%h", led_o, 16'hABCD);
        else passed++;
        bus(1'b1, 4'b0000, 32'hbfaf0000, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h0000ABCD) $display("FAIL led_read got=%h exp=%h", data_sram_rdata, 32'h0000ABCD);
        else passed++;
        bus(1'b1, 4'b0000, 32'hbfaf0100, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h0) $display("FAIL mmio_hole got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
        total++;
        if (err_o !== 1'b0) $display("FAIL mmio_hole_err got=%b exp=%b", err_o, 1'b0);
        else passed++;
        bus(1'b1, 4'b0011, 32'hbfaf0008, 32'h12345678);
        bus(1'b1, 4'b0000, 32'hbfaf0008, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h00005678) $display("FAIL scratch_lanes got=%h exp=%h", data_sram_rdata, 32'h00005678);
        else passed++;
        // Four RAM stores so far; the write to STORE_CNT must be ignored.
        bus(1'b1, 4'b1111, 32'hbfaf000c, 32'h12345678);
        bus(1'b1, 4'b0000, 32'hbfaf000c, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h4) $display("FAIL store_cnt_ro got=%h exp=%h", data_sram_rdata, 32'h4);
        else passed++;
    endtask

    task automatic test_unmapped();
        bus(1'b1, 4'b0000, 32'hbfaf0000, 32'h0);
        bus(1'b1, 4'b0000, 32'h80000000, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h0) $display("FAIL unmapped_rdata got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
        total++;
        if (err_o !== 1'b1) $display("FAIL unmapped_err got=%b exp=%b", err_o, 1'b1);
        else passed++;
        bus(1'b1, 4'b1111, 32'h80000000, 32'h0000FFFF);
        bus(1'b0, 4'b0000, 32'h0, 32'h0);
        total++;
        if (err_o !== 1'b1) $display("FAIL err_sticky got=%b exp=%b", err_o, 1'b1);
        else passed++;
        total++;
        if (led_o !== 16'hABCD) $display("FAIL unmapped_no_write got=%h exp=%h", led_o, 16'hABCD);
        else passed++;
    endtask

    task automatic test_async_reset();
        bus(1'b1, 4'b0000, 32'h00000010, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h11BB33DD) $display("FAIL pre_reset_read got=%h exp=%h", data_sram_rdata, 32'h11BB33DD);
        else passed++;
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (data_sram_rdata !== 32'h0) $display("FAIL async_rdata got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
        total++;
        if (led_o !== 16'h0) $display("FAIL async_led got=%h exp=%h", led_o, 16'h0);
        else passed++;
        total++;
        if (err_o !== 1'b0) $display("FAIL async_err got=%b exp=%b", err_o, 1'b0);
        else passed++;
        #2;
        resetn = 1'b1;
        bus(1'b1, 4'b0000, 32'h00000010, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h11BB33DD) $display("FAIL ram_retained got=%h exp=%h", data_sram_rdata, 32'h11BB33DD);
        else passed++;
        bus(1'b1, 4'b0000, 32'hbfaf0008, 32'h0);
        total++;
        if (data_sram_rdata !== 32'h0) $display("FAIL scratch_cleared got=%h exp=%h", data_sram_rdata, 32'h0);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_store_load();
        test_partial();
        test_back_to_back();
        test_timer();
        test_mmio();
        test_unmapped();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
